// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter
//   The L1 I-cache and the L1 D-cache share one L2 request port through this block.
//   The winning request is registered and held on the L2 port until l2_resp arrives.
//   The returned line is registered and handed back to the winner with a one-cycle
//   resp pulse.
//   D has priority over I. A starvation guard forces an I grant after STARVE_LIMIT
//   consecutive D grants taken while i_read was pending.
//
// Ports
//   clk, reset_n           clock, async active-low reset
//   i_read/i_addr          I-cache line read request (held until i_resp)
//   i_rdata/i_resp         line + completion pulse to I-cache
//   d_read/d_write/d_addr  D-cache read / writeback request (held until d_resp)
//   d_wdata                D-cache writeback line
//   d_rdata/d_resp         line + completion pulse to D-cache
//   l2_read/l2_write       one-hot (or idle) strobes to L2
//   l2_addr/l2_wdata       line-aligned address, writeback data to L2
//   l2_rdata/l2_resp       line and one-cycle completion from L2
//
// Optional build macro L1_L2_ARB_PERF_CNT_EN
//   Adds the saturating 32-bit counters perf_i_grants, perf_d_grants and
//   perf_i_wait_cycles.
module l1_l2_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int LINE_W       = 256,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
`ifdef L1_L2_ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_i_grants,
   output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_i_wait_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t            state, state_nxt;
   logic [3:0]        starve_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] rdata_q;
   logic              owner_i;   // 1 = I-cache owns the transaction, 0 = D-cache
   logic              write_q;

   logic d_req, grant_i, grant_d;

   // A simultaneous d_read and d_write is treated as a write (d_write is tested first).
   assign d_req   = d_read | d_write;
   assign grant_i = (state == IDLE) && i_read && (!d_req || (starve_cnt == LIMIT));
   assign grant_d = (state == IDLE) && d_req && !grant_i;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_i || grant_d) state_nxt = ISSUE;
         ISSUE:   if (l2_resp)            state_nxt = DONE;
         DONE:                            state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         owner_i    <= 1'b0;
         write_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            if (grant_i || !i_read)
               starve_cnt <= '0;
            else if (grant_d && starve_cnt != LIMIT)
               starve_cnt <= starve_cnt + 4'd1;
         end
         if (grant_i) begin
            addr_q  <= i_addr;
            owner_i <= 1'b1;
            write_q <= 1'b0;
         end else if (grant_d) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            owner_i <= 1'b0;
            write_q <= d_write;
         end
         if (state == ISSUE && l2_resp && !write_q)
            rdata_q <= l2_rdata;
      end
   end

   // All outputs come straight from async-reset state, so they drop as soon as reset is asserted.
   assign l2_read  = (state == ISSUE) && !write_q;
   assign l2_write = (state == ISSUE) &&  write_q;
   assign l2_addr  = {addr_q[ADDR_W-1:5], 5'b0};
   assign l2_wdata = wdata_q;
   assign i_resp   = (state == DONE) &&  owner_i;
   assign d_resp   = (state == DONE) && !owner_i;
   assign i_rdata  = rdata_q;
   assign d_rdata  = rdata_q;

`ifdef L1_L2_ARB_PERF_CNT_EN
   logic i_inflight;
   assign i_inflight = (state != IDLE) && owner_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_i_grants      <= '0;
         perf_d_grants      <= '0;
         perf_i_wait_cycles <= '0;
      end else begin
         if (grant_i && perf_i_grants != '1)
            perf_i_grants <= perf_i_grants + 32'd1;
         if (grant_d && perf_d_grants != '1)
            perf_d_grants <= perf_d_grants + 32'd1;
         if (i_read && !i_inflight && perf_i_wait_cycles != '1)
            perf_i_wait_cycles <= perf_i_wait_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter. Covers latency, writeback, priority, the starvation
// guard, async reset abort and (when built with the macro) the perf counters.
module tb_l1_l2_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          i_read, d_read, d_write, l2_resp;
   logic [AW-1:0] i_addr, d_addr;
   logic [LW-1:0] d_wdata, l2_rdata;
   logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
   logic          i_resp, d_resp, l2_read, l2_write;
   logic [AW-1:0] l2_addr;
`ifdef L1_L2_ARB_PERF_CNT_EN
   logic [31:0]   perf_i_grants, perf_d_grants, perf_i_wait_cycles;
`endif

   l1_l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_resp(l2_resp)
`ifdef L1_L2_ARB_PERF_CNT_EN
      , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_i_wait_cycles(perf_i_wait_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for an L2 strobe, then answer it with one l2_resp pulse. Afterwards
   // sample the L1 resp lines in the DONE cycle.
   task automatic serve(input logic [LW-1:0] data, output logic [AW-1:0] addr,
                        output logic was_wr, output logic got_i, output logic got_d);
      int n;
      n = 0;
      addr = '0; was_wr = 1'b0; got_i = 1'b0; got_d = 1'b0;
      while (!(l2_read || l2_write) && n < 20) begin
         tick();
         n++;
      end
      if (!(l2_read || l2_write)) begin
         chk("strobe_timeout", 0, 1);
         return;
      end
      addr     = l2_addr;
      was_wr   = l2_write;
      l2_rdata = data;
      l2_resp  = 1'b1;
      tick();
      l2_resp  = 1'b0;
      got_i    = i_resp;
      got_d    = d_resp;
   endtask

   // Independent view of perf_i_wait_cycles: I is in flight while its address is on the
   // L2 port as a read, or during its resp cycle.
   localparam logic [AW-1:0] IADDR_A = 32'h0000_1234;
   int exp_wait = 0;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) exp_wait = 0;
      else if (i_read && !((l2_read && l2_addr == {i_addr[AW-1:5], 5'b0}) || i_resp))
         exp_wait = exp_wait + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

   localparam logic [LW-1:0] PAT_A = {8{32'hA5A5_0001}};
   localparam logic [LW-1:0] PAT_B = {8{32'hB00B_0002}};
   localparam logic [LW-1:0] PAT_C = {8{32'hC0DE_0003}};

   initial begin
      logic [AW-1:0] a;
      logic          w, gi, gd;
      int            nd;
      logic          seen_i;

      reset_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
      #12;
      chk("rst_l2_read", l2_read, 0);
      chk("rst_l2_write", l2_write, 0);
      chk("rst_resp", {i_resp, d_resp}, 0);
      chk("rst_l2_addr", l2_addr, 0);
      chk("rst_rdata", i_rdata, 0);
      tick();
      reset_n = 1'b1;
      tick();

      // Single I read: strobe one cycle after sampling, aligned address, resp one cycle after l2_resp
      i_read = 1; i_addr = IADDR_A;
      tick();
      chk("t1_l2_read", l2_read, 1);
      chk("t1_l2_write", l2_write, 0);
      chk("t1_l2_addr", l2_addr, 32'h0000_1220);
      tick(); tick();
      chk("t1_hold", l2_read, 1);
      l2_rdata = PAT_A; l2_resp = 1;
      tick();
      l2_resp = 0;
      chk("t1_i_resp", i_resp, 1);
      chk("t1_d_resp", d_resp, 0);
      chk("t1_i_rdata", i_rdata, PAT_A);
      chk("t1_strobe_off", l2_read, 0);
      i_read = 0;
      tick();
      chk("t1_resp_1cyc", i_resp, 0);

      // Reset in ISSUE: strobe drops at once, nothing is issued afterwards, and a stray l2_resp is ignored
      i_read = 1; i_addr = 32'h0000_2200;
      tick();
      chk("rs_issue", l2_read, 1);
      reset_n = 0;
      #1;
      chk("rs_async_drop", l2_read, 0);
      chk("rs_rdata_clr", i_rdata, 0);
      i_read = 0;
      #2 reset_n = 1;
      tick();
      l2_resp = 1; l2_rdata = PAT_C;
      tick();
      l2_resp = 0;
      chk("rs_no_resp", {i_resp, d_resp, l2_read, l2_write}, 0);
      tick();
      chk("rs_no_resp2", {i_resp, d_resp, l2_read, l2_write}, 0);
      chk("rs_rdata_kept", i_rdata, 0);
      d_read = 1; d_addr = 32'h0000_0300;
      tick();
      chk("rs_idle_grant", {l2_read, l2_addr}, {1'b1, 32'h0000_0300});
      serve(PAT_C, a, w, gi, gd);
      chk("rs_d_resp", {gi, gd}, 2'b01);
      d_read = 0;
      tick();

      // D writeback
      d_write = 1; d_addr = 32'h8000_0040; d_wdata = PAT_B;
      tick();
      chk("t2_strobes", {l2_read, l2_write}, 2'b01);
      chk("t2_addr", l2_addr, 32'h8000_0040);
      chk("t2_wdata", l2_wdata, PAT_B);
      tick();
      chk("t2_hold", {l2_read, l2_write}, 2'b01);
      l2_resp = 1; l2_rdata = PAT_A;
      tick();
      l2_resp = 0;
      chk("t2_d_resp", {i_resp, d_resp, l2_write}, 3'b010);
      d_write = 0;
      tick();
      chk("t2_resp_1cyc", d_resp, 0);

      // Simultaneous I and D read: D first, then I granted in the IDLE cycle after d_resp
      i_read = 1; i_addr = 32'h0000_0200;
      d_read = 1; d_addr = 32'h0000_0100;
      tick();
      chk("t3_d_first", {l2_read, l2_addr}, {1'b1, 32'h0000_0100});
      serve(PAT_B, a, w, gi, gd);
      chk("t3_d_resp", {gi, gd}, 2'b01);
      chk("t3_d_rdata", d_rdata, PAT_B);
      d_read = 0;
      tick();
      chk("t3_idle_gap", {l2_read, l2_write}, 0);
      tick();
      chk("t3_i_next", {l2_read, l2_addr}, {1'b1, 32'h0000_0200});
      serve(PAT_C, a, w, gi, gd);
      chk("t3_i_resp", {gi, gd}, 2'b10);
      chk("t3_i_rdata", i_rdata, PAT_C);
      i_read = 0;
      tick();

      // Starvation: I held and D always requesting gives exactly 4 D grants, then the I grant
      i_read = 1; i_addr = IADDR_A;
      d_read = 1; d_addr = 32'h0000_0300;
      nd = 0; seen_i = 0;
      for (int k = 0; k < 5; k++) begin
         serve(PAT_A, a, w, gi, gd);
         if (gi) seen_i = 1;
         else if (gd && !seen_i) nd++;
      end
      chk("sv_d_grants", nd, 4);
      chk("sv_i_granted", seen_i, 1);
      // The counter restarted at the I grant, so the next grant goes to D again
      serve(PAT_A, a, w, gi, gd);
      chk("sv_after_i", {gi, gd, a}, {2'b01, 32'h0000_0300});
      i_read = 0; d_read = 0;
      tick(); tick();

`ifdef L1_L2_ARB_PERF_CNT_EN
      // Grants since the mid-test reset: D = 1 + 1 + 1 + 4 + 1 = 8, I = 1 + 1 = 2
      chk("pf_d_grants", perf_d_grants, 8);
      chk("pf_i_grants", perf_i_grants, 2);
      chk("pf_i_wait", perf_i_wait_cycles, exp_wait);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Shares the single unified-L2 request port between the L1 instruction cache and the L1 data cache.
- Sits between the two L1 miss paths and the L2 cache, in front of the L2-to-pmem arbiter.
- Registers the winning request, holds it on the L2 port until l2_resp, registers the returned line and returns it to the winner with a one-cycle resp pulse.
- Data-cache priority, with a starvation guard for the instruction cache.

Parameters:
- ADDR_W, 32, address width in bits
- LINE_W, 256, cache line width in bits
- STARVE_LIMIT, 4, consecutive D grants allowed while i_read is pending before I is forced; legal range 1..15

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  ADDR_W  I-cache request address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_addr  in  ADDR_W  D-cache request address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- l2_read  out  1  read strobe to L2
- l2_write  out  1  write strobe to L2
- l2_addr  out  ADDR_W  line-aligned address to L2
- l2_wdata  out  LINE_W  writeback data to L2
- l2_rdata  in  LINE_W  line from L2, valid with l2_resp
- l2_resp  in  1  L2 completion, one cycle

Behaviour:
- Reset: state=IDLE, starve_cnt=0, addr/wdata/rdata registers=0, owner=D. All outputs are 0 while reset_n=0.
- Reset mid-transaction aborts immediately. L2 strobes drop asynchronously, and no resp is issued after release.
- States:
  - IDLE: sample requests. On a grant, load the address/wdata registers and owner, then go to ISSUE.
  - ISSUE: drive l2_read or l2_write from the registered values; hold until l2_resp=1. On l2_resp, load the rdata register (reads only) and go to DONE.
  - DONE: assert i_resp or d_resp per owner for exactly one cycle, then go to IDLE.
- Grant rule in IDLE:
  - d_write or d_read wins over i_read, unless i_read=1 and starve_cnt==STARVE_LIMIT; then I wins.
  - d_read and d_write both high is illegal; treat it as a write.
- starve_cnt:
  - Increments, saturating, on each D grant while i_read=1.
  - Clears on any I grant or on any IDLE cycle with i_read=0.
- Address and data:
  - l2_addr = {registered addr[ADDR_W-1:5], 5'b0}.
  - l2_wdata is driven from the wdata register.
  - Strobes are exactly one-hot or zero.
- Outputs:
  - i_rdata and d_rdata both drive the rdata register.
  - Contents are only meaningful in the cycle of the matching resp.
- Latency: request sampled in IDLE at cycle N, so l2 strobe at N+1. l2_resp at cycle K gives L1 resp at K+1, then IDLE at K+2.
- Turnaround: IDLE is the earliest a new grant can occur after DONE. A requester that drops its request on seeing resp is therefore never re-granted.
- Request changes while not in IDLE are ignored; the registered values are used.
- l2_resp outside ISSUE is ignored.

Optional Feature:
- Macro: L1_L2_ARB_PERF_CNT_EN.
- When defined, adds three 32-bit outputs:
  - perf_i_grants
  - perf_d_grants
  - perf_i_wait_cycles: cycles with i_read=1 and I not owner-in-flight
- All three saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and counters are absent and the block is otherwise identical.

Test Plan:
- Single I read at 0x0000_1234; L2 responds after 3 cycles with pattern A -> l2_read at N+1, l2_addr=0x0000_1220, i_resp pulse one cycle after l2_resp, i_rdata=A, d_resp never set.
- d_write to 0x8000_0040 with wdata B -> l2_write=1 and l2_wdata=B until l2_resp, then d_resp one cycle; l2_read stays 0.
- i_read and d_read raised in the same cycle -> D served first, then I granted in the IDLE cycle after d_resp; two separate L2 transactions.
- STARVE_LIMIT=4, d_read re-asserted immediately after every d_resp and i_read held -> exactly 4 D grants, then the I grant, then starve_cnt=0.
- reset_n driven low during ISSUE with l2_read=1 -> l2_read=0 asynchronously. After release, state=IDLE, no i_resp/d_resp, and a later l2_resp pulse is ignored.
- With L1_L2_ARB_PERF_CNT_EN: 3 D grants and 2 I grants -> perf_d_grants=3, perf_i_grants=2, and perf_i_wait_cycles equals the cycle count i_read was held before its grants.
